// File: rtl/router_fifo.sv
// Per-port output buffer of the 1x3 router: holds header/payload/parity bytes tagged with a
// header flag, and tracks how many bytes of the packet being read out are still to come.
module router_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          soft_rst,
    input  logic          we,
    input  logic          re,
    input  logic          lfd_state,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic          pkt_busy
);

    localparam logic [AW:0]   PTR_ONE = 1;
    localparam logic [DW-2:0] CNT_ONE = 1;

    logic [DW:0]   mem [DEPTH];
    logic [DW:0]   rd_entry;
    logic          wr_en;

    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [DW-2:0] pkt_cnt_q, pkt_cnt_d;

    // Extra pointer MSB distinguishes a full buffer from an empty one.
    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pkt_busy = (pkt_cnt_q != '0);
    assign dout     = dout_q;

    always_comb begin
        rd_entry = mem[rptr_q[AW-1:0]];
    end

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        dout_d    = dout_q;
        pkt_cnt_d = pkt_cnt_q;
        wr_en     = 1'b0;
        if (soft_rst) begin
            wptr_d    = '0;
            rptr_d    = '0;
            dout_d    = '0;
            pkt_cnt_d = '0;
        end else begin
            if (we && !full) begin
                wr_en  = 1'b1;
                wptr_d = wptr_q + PTR_ONE;
            end
            if (re && !empty) begin
                rptr_d = rptr_q + PTR_ONE;
                dout_d = rd_entry[DW-1:0];
                // Header length field counts payload bytes; the parity byte adds one more.
                if (rd_entry[DW]) begin
                    pkt_cnt_d = {1'b0, rd_entry[DW-1:2]} + CNT_ONE;
                end else if (pkt_cnt_q != '0) begin
                    pkt_cnt_d = pkt_cnt_q - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            dout_q    <= '0;
            pkt_cnt_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            dout_q    <= dout_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q[AW-1:0]] <= {lfd_state, din};
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Randomised scoreboard bench for router_fifo: a queue-based reference model predicts
// read data, flags and packet progress; a monitor compares after every clock edge.
module tb_router_fifo;

    logic       clk;
    logic       rst;
    logic       soft_rst;
    logic       we;
    logic       re;
    logic       lfd_state;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic       pkt_busy;

    router_fifo #(.DEPTH(16), .AW(4), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .soft_rst  (soft_rst),
        .we        (we),
        .re        (re),
        .lfd_state (lfd_state),
        .din       (din),
        .dout      (dout),
        .full      (full),
        .empty     (empty),
        .pkt_busy  (pkt_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: stored entries, last read byte, bytes left in current packet
    logic [8:0] m_q[$];
    logic [7:0] m_dout;
    int         m_left;
    logic [7:0] exp_q[$];
    logic       rd_fire;

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        exp_q.delete();
        m_dout = 8'h00;
        m_left = 0;
    endtask

    // driver: one clock of stimulus, applied at the falling edge, model advanced to the
    // state expected after the following rising edge
    task automatic drive(input logic w, input logic r, input logic l,
                         input logic [7:0] d, input logic s);
        logic [8:0] e;
        bit         was_full;
        bit         was_empty;
        @(negedge clk);
        we        = w;
        re        = r;
        lfd_state = l;
        din       = d;
        soft_rst  = s;
        rd_fire   = 1'b0;
        was_full  = (m_q.size() == 16);
        was_empty = (m_q.size() == 0);
        if (s) begin
            model_clear();
        end else begin
            if (r && !was_empty) begin
                e = m_q.pop_front();
                m_dout = e[7:0];
                exp_q.push_back(e[7:0]);
                rd_fire = 1'b1;
                if (e[8]) m_left = int'(e[7:2]) + 1;
                else if (m_left > 0) m_left = m_left - 1;
            end
            if (w && !was_full) m_q.push_back({l, d});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        we = 1'b0; re = 1'b0; lfd_state = 1'b0; din = 8'h00; soft_rst = 1'b0;
        rd_fire = 1'b0;
        #2 rst = 1'b0;
        model_clear();
        #1;
        check("rst_dout", {24'd0, dout}, 32'h00);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_pkt_busy", {31'd0, pkt_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // monitor: pops the scoreboard on each predicted read and checks flags every edge
    always @(posedge clk) begin
        #1;
        if (rd_fire) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                check("read_data", {24'd0, dout}, {24'd0, exp_q.pop_front()});
            end
        end
        check("dout_hold", {24'd0, dout}, {24'd0, m_dout});
        check("empty", {31'd0, empty}, {31'd0, m_q.size() == 0});
        check("full", {31'd0, full}, {31'd0, m_q.size() == 16});
        check("pkt_busy", {31'd0, pkt_busy}, {31'd0, m_left != 0});
    end

    initial begin
        logic [7:0] b;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0; soft_rst = 1'b0; we = 1'b0; re = 1'b0; lfd_state = 1'b0; din = 8'h00;
        rd_fire = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        check("por_empty", {31'd0, empty}, 32'd1);
        check("por_dout", {24'd0, dout}, 32'h00);
        rst = 1'b1;

        // packet round trip: header 0C announces 3 payload bytes plus parity
        drive(1'b1, 1'b0, 1'b1, 8'h0C, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        idle(2);

        // fill, overflow attempt, drain
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b0, 8'(i), 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        idle(1);

        // simultaneous access when full, then when empty
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b0, 8'(8'h20 + i), 1'b0);
        drive(1'b1, 1'b1, 1'b0, 8'h55, 1'b0);
        for (int i = 0; i < 15; i++) drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 8'h33, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        idle(1);

        // wrap-around in bursts of ten
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
            for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        end
        idle(1);

        // asynchronous reset in the middle of a packet
        drive(1'b1, 1'b0, 1'b1, 8'h10, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h12, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        async_reset();
        idle(2);

        // soft reset with six entries left and a packet in progress, concurrent write dropped
        drive(1'b1, 1'b0, 1'b1, 8'h14, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0, 8'(8'h40 + i), 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h77, 1'b1);
        idle(2);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // random traffic: occasional headers and rare soft resets
        for (int i = 0; i < 400; i++) begin
            b = 8'($urandom_range(0, 255));
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), b, ($urandom_range(0, 63) == 0));
        end
        for (int i = 0; i < 17; i++) drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
